// File: rtl/trigger_out_sync.sv
// Serial trigger event encoder: latches event requests and sends each as a 3-bit frame (1, code[1], code[0]).
// Latency: start bit on the first sync tick after the request edge when idle; no backpressure, a repeat of a pending request is merged and flagged on drop.
// Optional TRIGGER_OUT_GAP_EN inserts one forced 0 bit after every frame.
module trigger_out_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic [3:0] req,
    output logic       dout,
    output logic       busy,
    output logic [3:0] pending,
    output logic       frame_start,
    output logic       drop
);

`ifdef TRIGGER_OUT_GAP_EN
    typedef enum logic [1:0] {IDLE, B1, B0, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, B1, B0} state_t;
`endif

    state_t     state;
    logic [1:0] code;
    logic [3:0] win;
    logic [1:0] win_code;
    logic       take;
    logic [3:0] consume;

    // Fixed priority rst > rsr > trg > syn, which is pending[3] down to pending[0].
    always_comb begin
        win      = 4'b0000;
        win_code = 2'b00;
        if (pending[3]) begin
            win      = 4'b1000;
            win_code = 2'b01;
        end else if (pending[2]) begin
            win      = 4'b0100;
            win_code = 2'b11;
        end else if (pending[1]) begin
            win      = 4'b0010;
            win_code = 2'b10;
        end else if (pending[0]) begin
            win      = 4'b0001;
            win_code = 2'b00;
        end
    end

    assign take    = sync && (state == IDLE) && (pending != 4'b0000);
    assign consume = take ? win : 4'b0000;
    assign busy    = (state != IDLE);

    // A request landing on the consuming edge re-arms the bit, so it is not a drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 4'b0000;
            drop    <= 1'b0;
        end else begin
            pending <= (pending & ~consume) | req;
            drop    <= |(req & pending & ~consume);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            code        <= 2'b00;
            dout        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (sync) begin
                case (state)
                    IDLE: begin
                        if (take) begin
                            dout        <= 1'b1;
                            code        <= win_code;
                            frame_start <= 1'b1;
                            state       <= B1;
                        end else begin
                            dout <= 1'b0;
                        end
                    end
                    B1: begin
                        dout  <= code[1];
                        state <= B0;
                    end
                    B0: begin
                        dout <= code[0];
`ifdef TRIGGER_OUT_GAP_EN
                        state <= GAP;
`else
                        state <= IDLE;
`endif
                    end
`ifdef TRIGGER_OUT_GAP_EN
                    GAP: begin
                        dout  <= 1'b0;
                        state <= IDLE;
                    end
`endif
                    default: begin
                        dout  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_out_sync.sv
// Scoreboarded bench for trigger_out_sync: a bit-queue reference model predicts each cycle and each frame code.
module tb_trigger_out_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync;
    logic [3:0] req;
    logic       dout;
    logic       busy;
    logic [3:0] pending;
    logic       frame_start;
    logic       drop;

    trigger_out_sync dut (
        .clk         (clk),
        .reset       (reset),
        .sync        (sync),
        .req         (req),
        .dout        (dout),
        .busy        (busy),
        .pending     (pending),
        .frame_start (frame_start),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dout;
        logic       busy;
        logic       fs;
        logic       drop;
        logic [3:0] pend;
    } rec_t;

    rec_t       expq[$];
    logic [1:0] frameq[$];
    logic       bitq[$];
    logic [3:0] m_pend = 4'b0000;
    logic       m_line = 1'b0;
    logic [1:0] cmap [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int         n_checks = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is a list of bits still to shift out; the line pops one per tick.
    task automatic model_update(input logic s, input logic [3:0] r, input logic rs);
        rec_t       e;
        logic [3:0] cons;
        logic [1:0] c;
        int         w;
        e.fs   = 1'b0;
        e.drop = 1'b0;
        cons   = 4'b0000;
        if (rs) begin
            m_pend = 4'b0000;
            m_line = 1'b0;
            bitq.delete();
            frameq.delete();
        end else begin
            if (s) begin
                if (bitq.size() > 0) begin
                    m_line = bitq.pop_front();
                end else if (m_pend != 4'b0000) begin
                    w = 3;
                    while (!m_pend[w]) w--;
                    c = cmap[w];
                    m_line = 1'b1;
                    e.fs   = 1'b1;
                    bitq.push_back(c[1]);
                    bitq.push_back(c[0]);
`ifdef TRIGGER_OUT_GAP_EN
                    bitq.push_back(1'b0);
`endif
                    frameq.push_back(c);
                    cons[w] = 1'b1;
                end else begin
                    m_line = 1'b0;
                end
            end
            e.drop = |(r & m_pend & ~cons);
            m_pend = (m_pend & ~cons) | r;
        end
        e.dout = m_line;
        e.busy = (bitq.size() > 0);
        e.pend = m_pend;
        expq.push_back(e);
    endtask

    task automatic step(input logic s, input logic [3:0] r, input logic rs);
        @(negedge clk);
        #1;
        sync  = s;
        req   = r;
        reset = rs;
        @(posedge clk);
        model_update(s, r, rs);
    endtask

    task automatic ticks(input int n, input int period);
        for (int i = 0; i < n * period; i++) step((i % period) == period - 1, 4'b0000, 1'b0);
    endtask

    // Asynchronous reset mid-cycle, outputs checked before the next edge.
    task automatic reset_now();
        @(negedge clk);
        #1;
        reset = 1'b1;
        sync  = 1'b1;
        req   = 4'b0000;
        #1;
        chk("async_reset_dout", {3'b0, dout}, 4'h0);
        chk("async_reset_busy", {3'b0, busy}, 4'h0);
        chk("async_reset_pending", pending, 4'h0);
        @(posedge clk);
        model_update(1'b1, 4'b0000, 1'b1);
    endtask

    // Monitor: per-cycle compare plus a line decoder that checks each completed frame code.
    initial begin
        rec_t       e;
        logic       tk;
        logic       rs;
        logic       c1 = 1'b0;
        int         dcnt = 0;
        logic [1:0] got;
        logic [1:0] want;
        forever begin
            @(posedge clk);
            tk = sync && !reset;
            rs = reset;
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("dout", {3'b0, dout}, {3'b0, e.dout});
                chk("busy", {3'b0, busy}, {3'b0, e.busy});
                chk("frame_start", {3'b0, frame_start}, {3'b0, e.fs});
                chk("drop", {3'b0, drop}, {3'b0, e.drop});
                chk("pending", pending, e.pend);
            end
            if (rs) begin
                dcnt = 0;
            end else if (tk) begin
                case (dcnt)
                    0: if (dout) dcnt = 1;
                    1: begin
                        c1   = dout;
                        dcnt = 2;
                    end
                    default: begin
                        got  = {c1, dout};
                        dcnt = 0;
                        if (frameq.size() == 0) begin
                            chk("unexpected_frame", {2'b0, got}, 4'hf);
                        end else begin
                            want = frameq.pop_front();
                            chk("frame_code", {2'b0, got}, {2'b0, want});
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        logic       s;
        logic [3:0] r;
        logic       rs;
        reset = 1'b1;
        sync  = 1'b0;
        req   = 4'b0000;
        #2;
        chk("reset_dout", {3'b0, dout}, 4'h0);
        chk("reset_busy", {3'b0, busy}, 4'h0);
        chk("reset_pending", pending, 4'h0);
        chk("reset_flags", {2'b0, frame_start, drop}, 4'h0);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Single trg with sync every 4 clk.
        step(1'b0, 4'b0010, 1'b0);
        ticks(6, 4);

        // All four at once, back-to-back frames on continuous sync.
        step(1'b0, 4'b1111, 1'b0);
        ticks(18, 1);

        // Duplicate syn before the first tick.
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        ticks(6, 2);

        // trg re-requested on the tick that consumes it.
        step(1'b0, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        ticks(10, 2);

        // Reset while sending rst's code[0] slot, with rsr still pending.
        step(1'b0, 4'b1100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        reset_now();
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        ticks(8, 1);

        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 2) == 0);
            if (i >= 1500 && i < 1800) s = 1'b1;
            r = 4'b0000;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) r[b] = 1'b1;
            rs = ($urandom_range(0, 399) == 0);
            step(s, r, rs);
        end

        ticks(30, 1);
        step(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        #2;
        chk("frames_outstanding", frameq.size() > 0 ? 4'h1 : 4'h0, 4'h0);
        chk("records_outstanding", expq.size() > 0 ? 4'h1 : 4'h0, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
